// File: rtl/swipe_detector.sv
// swipe_detector: tracks the per-frame motion zone and pulses oSwipeAsc/oSwipeDesc one clock after a monotonic sweep completes; no backpressure.
// Define SWIPE_CNT_EN to get the wrapping swipe counter on oSwipeCnt (tied to 0 otherwise).
module swipe_detector #(
  parameter int SAMPLE_H        = 1016,
  parameter int SAMPLE_V        = 626,
  parameter int SPAN            = 3,
  parameter int MAX_STEP        = 2,
  parameter int MAX_GAP         = 2,
  parameter int TIMEOUT_FRAMES  = 30,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [12:0] iH_Cont,
  input  logic [12:0] iV_Cont,
  input  logic [2:0]  iDirection,
  input  logic        iMotion,
  output logic        oSwipeAsc,
  output logic        oSwipeDesc,
  output logic        oBusy,
  output logic [2:0]  oLastZone,
  output logic [7:0]  oSwipeCnt
);
  localparam int AW = $clog2(TIMEOUT_FRAMES + 1);
  localparam int GW = $clog2(MAX_GAP + 2);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, ARM, ASC, DESC, HOLD} state_t;

  state_t        state, trkState;
  logic [2:0]    start, last, trkLast;
  logic [GW-1:0] gap, gapInc;
  logic [AW-1:0] age, ageInc;
  logic [CW-1:0] cool, coolInc;
  logic          strobe, zoneValid, tracking, rearm, same, stepUp, stepDown;
  logic          ascDone, descDone, complete;
  logic [3:0]    upDiff, downDiff, ascSpan, descSpan;

  assign strobe    = (iH_Cont == 13'(SAMPLE_H)) && (iV_Cont == 13'(SAMPLE_V));
  assign zoneValid = iMotion && (iDirection != 3'd7);
  assign tracking  = (state == ARM) || (state == ASC) || (state == DESC);
  assign gapInc    = gap + GW'(1);
  assign ageInc    = age + AW'(1);
  assign coolInc   = cool + CW'(1);

  assign upDiff   = {1'b0, iDirection} - {1'b0, last};
  assign downDiff = {1'b0, last} - {1'b0, iDirection};
  assign same     = (iDirection == last);
  assign stepUp   = (iDirection > last) && (upDiff <= 4'(MAX_STEP));
  assign stepDown = (iDirection < last) && (downDiff <= 4'(MAX_STEP));

  // Where a valid zone would take the sweep; anything not continuing it re-arms.
  always_comb begin
    trkState = state;
    trkLast  = last;
    rearm    = 1'b0;
    if (!same) begin
      if (stepUp && state != DESC) begin
        trkState = ASC;
        trkLast  = iDirection;
      end else if (stepDown && state != ASC) begin
        trkState = DESC;
        trkLast  = iDirection;
      end else begin
        rearm = 1'b1;
      end
    end
  end

  assign ascSpan  = {1'b0, trkLast} - {1'b0, start};
  assign descSpan = {1'b0, start} - {1'b0, trkLast};
  assign ascDone  = (trkState == ASC) && (trkLast >= start) && (ascSpan >= 4'(SPAN));
  assign descDone = (trkState == DESC) && (trkLast <= start) && (descSpan >= 4'(SPAN));
  assign complete = strobe && tracking && zoneValid && !rearm && (ascDone || descDone);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      start      <= 3'd0;
      last       <= 3'd0;
      gap        <= '0;
      age        <= '0;
      cool       <= '0;
      oSwipeAsc  <= 1'b0;
      oSwipeDesc <= 1'b0;
      oBusy      <= 1'b0;
      oLastZone  <= 3'd7;
    end else begin
      oSwipeAsc  <= 1'b0;
      oSwipeDesc <= 1'b0;
      if (strobe) begin
        case (state)
          IDLE: begin
            if (zoneValid) begin
              state     <= ARM;
              start     <= iDirection;
              last      <= iDirection;
              gap       <= '0;
              age       <= '0;
              oBusy     <= 1'b1;
              oLastZone <= iDirection;
            end
          end
          ARM, ASC, DESC: begin
            // Priority: completion, timeout, gap abort, re-arm, normal tracking.
            if (complete) begin
              state      <= HOLD;
              last       <= trkLast;
              oLastZone  <= trkLast;
              gap        <= '0;
              cool       <= '0;
              oSwipeAsc  <= ascDone;
              oSwipeDesc <= descDone;
            end else if (ageInc >= AW'(TIMEOUT_FRAMES)) begin
              state     <= IDLE;
              gap       <= '0;
              age       <= '0;
              oBusy     <= 1'b0;
              oLastZone <= 3'd7;
            end else if (!zoneValid) begin
              if (gapInc > GW'(MAX_GAP)) begin
                state     <= IDLE;
                gap       <= '0;
                age       <= '0;
                oBusy     <= 1'b0;
                oLastZone <= 3'd7;
              end else begin
                gap <= gapInc;
                age <= ageInc;
              end
            end else if (rearm) begin
              state     <= ARM;
              start     <= iDirection;
              last      <= iDirection;
              gap       <= '0;
              age       <= '0;
              oLastZone <= iDirection;
            end else begin
              state     <= trkState;
              last      <= trkLast;
              oLastZone <= trkLast;
              gap       <= '0;
              age       <= ageInc;
            end
          end
          HOLD: begin
            // The frame that ends the cooldown is consumed here, not re-sampled as IDLE.
            if (coolInc >= CW'(COOLDOWN_FRAMES)) begin
              state     <= IDLE;
              cool      <= '0;
              oBusy     <= 1'b0;
              oLastZone <= 3'd7;
            end else begin
              cool <= coolInc;
            end
          end
          default: begin
            state     <= IDLE;
            oBusy     <= 1'b0;
            oLastZone <= 3'd7;
          end
        endcase
      end
    end
  end

`ifdef SWIPE_CNT_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      oSwipeCnt <= 8'd0;
    else if (complete)
      oSwipeCnt <= oSwipeCnt + 8'd1;
  end
`else
  assign oSwipeCnt = 8'd0;
`endif

endmodule

// File: tb/tb_swipe_detector.sv
// Scoreboard bench for swipe_detector: directed sweeps plus a random zone walk against a queue-based reference model.
module tb_swipe_detector;
  localparam int SH       = 1016;
  localparam int SV       = 626;
  localparam int SPAN     = 3;
  localparam int MAX_STEP = 2;
  localparam int MAX_GAP  = 2;
  localparam int TIMEOUT  = 30;
  localparam int COOLDOWN = 8;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b1;
  logic [12:0] iH_Cont = 13'd0;
  logic [12:0] iV_Cont = 13'd0;
  logic [2:0]  iDirection = 3'd0;
  logic        iMotion = 1'b0;
  logic        oSwipeAsc, oSwipeDesc, oBusy;
  logic [2:0]  oLastZone;
  logic [7:0]  oSwipeCnt;

  swipe_detector #(
    .SAMPLE_H(SH), .SAMPLE_V(SV), .SPAN(SPAN), .MAX_STEP(MAX_STEP),
    .MAX_GAP(MAX_GAP), .TIMEOUT_FRAMES(TIMEOUT), .COOLDOWN_FRAMES(COOLDOWN)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iH_Cont(iH_Cont), .iV_Cont(iV_Cont),
    .iDirection(iDirection), .iMotion(iMotion), .oSwipeAsc(oSwipeAsc),
    .oSwipeDesc(oSwipeDesc), .oBusy(oBusy), .oLastZone(oLastZone), .oSwipeCnt(oSwipeCnt)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic       asc;
    logic       desc;
    logic       busy;
    logic [2:0] last;
    logic [7:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;
  int   ascSeen = 0;
  int   descSeen = 0;

  // Reference model: 0 idle, 1 tracking a sweep, 2 cooling down.
  int mMode = 0;
  int mAge = 0;
  int mGap = 0;
  int mCool = 0;
  int mCnt = 0;
  int run[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mAge = 0; mGap = 0; mCool = 0; mCnt = 0;
    run.delete();
  endtask

  task automatic modelStrobe(input bit mot, input int d, output exp_t e);
    bit valid, accept, fireA, fireD;
    int step, trend, span;
    valid = mot && (d != 7);
    accept = 1'b0; fireA = 1'b0; fireD = 1'b0;
    step = 0; trend = 0; span = 0;
    if (mMode == 0) begin
      if (valid) begin
        run.delete(); run.push_back(d);
        mAge = 0; mGap = 0; mMode = 1;
      end
    end else if (mMode == 1) begin
      mAge++;
      if (valid) begin
        step  = d - run[$];
        trend = run[$] - run[0];
        accept = (step == 0) ||
                 (step <= MAX_STEP && step >= -MAX_STEP &&
                  !(trend > 0 && step < 0) && !(trend < 0 && step > 0));
        if (accept && step != 0) begin
          span  = d - run[0];
          fireA = (span >= SPAN);
          fireD = (-span >= SPAN);
        end
      end
      if (fireA || fireD) begin
        run.push_back(d);
        mMode = 2; mCool = 0;
`ifdef SWIPE_CNT_EN
        mCnt = (mCnt + 1) % 256;
`endif
      end else if (mAge >= TIMEOUT) begin
        mMode = 0;
      end else if (!valid) begin
        mGap++;
        if (mGap > MAX_GAP) mMode = 0;
      end else if (!accept) begin
        run.delete(); run.push_back(d);
        mAge = 0; mGap = 0;
      end else begin
        if (step != 0) run.push_back(d);
        mGap = 0;
      end
    end else begin
      mCool++;
      if (mCool >= COOLDOWN) mMode = 0;
    end
    e.asc  = fireA;
    e.desc = fireD;
    e.busy = (mMode != 0);
    e.last = (mMode == 0) ? 3'd7 : 3'(run[$]);
    e.cnt  = 8'(mCnt);
  endtask

  // Off-strobe cycles carry junk that the DUT must ignore, including near-miss counters.
  task automatic scramble();
    int k;
    k = $urandom_range(0, 2);
    iH_Cont = 13'($urandom_range(0, 8191));
    iV_Cont = 13'($urandom_range(0, 8191));
    if (k == 0) iH_Cont = 13'(SH);
    else if (k == 1) iV_Cont = 13'(SV);
    if (iH_Cont == 13'(SH) && iV_Cont == 13'(SV)) iV_Cont = iV_Cont + 13'd1;
    iMotion    = 1'($urandom_range(0, 1));
    iDirection = 3'($urandom_range(0, 7));
  endtask

  task automatic frame(input bit mot, input int d);
    exp_t e;
    @(negedge iCLK);
    iH_Cont = 13'(SH); iV_Cont = 13'(SV);
    iMotion = mot; iDirection = 3'(d);
    modelStrobe(mot, d, e);
    expQ.push_back(e);
    @(negedge iCLK);
    scramble();
    repeat ($urandom_range(0, 2)) begin
      @(negedge iCLK);
      scramble();
    end
  endtask

  task automatic sweep(input int a, input int b);
    int s;
    s = (b >= a) ? 1 : -1;
    for (int z = a; z != b + s; z += s) frame(1'b1, z);
  endtask

  task automatic flush();
    repeat (COOLDOWN) frame(1'b0, 0);
  endtask

  // Monitor: every strobe edge pops one expected frame; all other cycles must be pulse-free.
  initial begin : monitor
    bit   wasStrobe;
    exp_t e;
    exp_t a;
    forever begin
      @(posedge iCLK);
      wasStrobe = iRST_N && (iH_Cont == 13'(SH)) && (iV_Cont == 13'(SV));
      @(negedge iCLK);
      a = {oSwipeAsc, oSwipeDesc, oBusy, oLastZone, oSwipeCnt};
      if (wasStrobe) begin
        if (expQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard: strobe seen with no expected frame queued");
        end else begin
          e = expQ.pop_front();
          check("frame outputs {asc,desc,busy,last,cnt}", 32'(a), 32'(e));
          ascSeen  += int'(oSwipeAsc);
          descSeen += int'(oSwipeDesc);
        end
      end else begin
        check("no pulse off-strobe", 32'({oSwipeAsc, oSwipeDesc}), 32'd0);
      end
    end
  end

  initial begin : driver
    int cur, dirW, r, s;
    scramble();
    #1 iRST_N = 1'b0;
    #2 check("reset outputs", 32'({oSwipeAsc, oSwipeDesc, oBusy, oLastZone, oSwipeCnt}),
             32'({1'b0, 1'b0, 1'b0, 3'd7, 8'd0}));
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    modelReset();

    sweep(1, 4); flush();
    frame(1, 5); frame(1, 4); frame(1, 4); frame(1, 3); frame(1, 2); flush();
    frame(1, 1); frame(1, 7); frame(1, 7); frame(1, 2); frame(1, 3); frame(1, 4); flush();
    frame(1, 1); frame(1, 7); frame(1, 7); frame(1, 7);
    frame(1, 0); frame(1, 3); frame(1, 4); frame(1, 5); frame(1, 6); flush();
    repeat (TIMEOUT + 1) frame(1, 2);
    frame(1'b0, 0);
    sweep(1, 4); sweep(4, 6); repeat (COOLDOWN - 3) frame(1'b0, 0);
    sweep(1, 4); flush();

    // Asynchronous reset in the middle of an ascending sweep.
    sweep(1, 3);
    @(posedge iCLK);
    #2 check("busy before reset", 32'(oBusy), 32'd1);
    iRST_N = 1'b0;
    #1 check("async reset outputs", 32'({oSwipeAsc, oSwipeDesc, oBusy, oLastZone, oSwipeCnt}),
             32'({1'b0, 1'b0, 1'b0, 3'd7, 8'd0}));
    modelReset();
    @(negedge iCLK);
    iH_Cont = 13'(SH); iV_Cont = 13'(SV); iMotion = 1'b1; iDirection = 3'd0;
    @(negedge iCLK);
    scramble();
    check("strobe ignored in reset", 32'({oBusy, oLastZone}), 32'({1'b0, 3'd7}));
    iRST_N = 1'b1;
    sweep(0, 3); flush();

    check("directed ascending pulses", 32'(ascSeen), 32'd6);
    check("directed descending pulses", 32'(descSeen), 32'd1);

    cur = 3; dirW = 1;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        if ($urandom_range(0, 1) == 1) frame(1'b0, $urandom_range(0, 7));
        else frame(1'b1, 7);
      end else if (r < 20) begin
        cur = $urandom_range(0, 6);
        frame(1'b1, cur);
      end else begin
        if (r < 28) dirW = -dirW;
        s = $urandom_range(0, 2);
        cur += dirW * s;
        if (cur > 6) begin cur = 6; dirW = -1; end
        if (cur < 0) begin cur = 0; dirW = 1; end
        frame(1'b1, cur);
      end
    end

    repeat (3) @(negedge iCLK);
    #1 check("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
